// File: rtl/demux_1to4_sequencer_pkg.sv
// Shared encodings for the 1-to-4 demux sequencer.
// State codes, channel count and select width.
package demux_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_DRIVE = DRIVE,
    ST_DONE  = DONE
  } state_e;

endpackage

// File: rtl/demux_1to4_sequencer_next_ch.sv
// Next enabled channel lookup: lowest set mask bit,
// strictly above ch unless first is set.
module demux_seq_next_ch
  import demux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  ch,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Scan high to low so the lowest qualifying bit wins.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(ch)))) begin
        nxt   = SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1to4_sequencer.sv
// Walks the enabled channels of a captured word and
// drives i/s1/s0/e of a 1-to-4 demux, one bit per channel.
module demux_1to4_sequencer
  import demux_seq_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_data,
  input  logic [3:0]  in_mask,
  output logic        i,
  output logic        s0,
  output logic        s1,
  output logic        e,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] TC = 8'(STEP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        data_q, data_d;
  logic [3:0]        mask_q, mask_d;
  logic              e_q, e_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              i_q, i_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              idle;
  logic              accept;
  logic [3:0]        look_mask;
  logic [SEL_W-1:0]  nxt;
  logic              found;

  assign idle      = (state_q == ST_IDLE);
  assign in_ready  = idle & ~rst;
  assign accept    = in_valid & in_ready;
  assign look_mask = idle ? in_mask : mask_q;

  demux_seq_next_ch u_next (
    .mask  (look_mask),
    .ch    (ch_q),
    .first (idle),
    .nxt   (nxt),
    .found (found)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mask_d  = mask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d = in_data;
          mask_d = in_mask;
          cnt_d  = '0;
          ch_d   = found ? nxt : '0;
          state_d = found ? ST_DRIVE : ST_DONE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == TC) begin
          cnt_d = '0;
          if (found) begin
            ch_d = nxt;
          end else begin
            ch_d    = '0;
            state_d = ST_DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        ch_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        ch_d    = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view.
  always_comb begin
    e_d    = (state_d == ST_DRIVE);
    sel_d  = e_d ? ch_d : '0;
    i_d    = e_d & data_d[ch_d];
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      e_q     <= 1'b0;
      sel_q   <= '0;
      i_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      e_q     <= e_d;
      sel_q   <= sel_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign e    = e_q;
  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign i    = i_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_demux_1to4_sequencer.sv
// Directed bench: dut a uses STEP_CYCLES=1, dut b uses 3.
// Observed vector is {e,s1,s0,i,done,busy,in_ready}.
module tb_demux_1to4_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0;
  logic vb = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] msk = '0;

  logic rdy_a, i_a, s0_a, s1_a, e_a, busy_a, done_a;
  logic rdy_b, i_b, s0_b, s1_b, e_b, busy_b, done_b;
  logic [6:0] obs_a, obs_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign obs_a = {e_a, s1_a, s0_a, i_a, done_a, busy_a, rdy_a};
  assign obs_b = {e_b, s1_b, s0_b, i_b, done_b, busy_b, rdy_b};

  demux_1to4_sequencer #(.STEP_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(va), .in_ready(rdy_a),
    .in_data(din), .in_mask(msk),
    .i(i_a), .s0(s0_a), .s1(s1_a), .e(e_a),
    .busy(busy_a), .done(done_a)
  );

  demux_1to4_sequencer #(.STEP_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(vb), .in_ready(rdy_b),
    .in_data(din), .in_mask(msk),
    .i(i_b), .s0(s0_b), .s1(s1_b), .e(e_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (obs_a !== 7'b0000000) begin
      bad++;
      $display("FAIL rst_a: obs=%b exp=%b", obs_a, 7'b0000000);
    end
    total++;
    if (obs_b !== 7'b0000000) begin
      bad++;
      $display("FAIL rst_b: obs=%b exp=%b", obs_b, 7'b0000000);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs_a !== 7'b0000001) begin
      bad++;
      $display("FAIL idle_a: obs=%b exp=%b", obs_a, 7'b0000001);
    end
    total++;
    if (obs_b !== 7'b0000001) begin
      bad++;
      $display("FAIL idle_b: obs=%b exp=%b", obs_b, 7'b0000001);
    end
  endtask

  task automatic test_full_mask();
    logic [6:0] t [6] = '{
      7'b1000010, 7'b1011010, 7'b1100010,
      7'b1111010, 7'b0000110, 7'b0000001
    };
    din = 4'b1010;
    msk = 4'hF;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      total++;
      if (obs_a !== t[j]) begin
        bad++;
        $display("FAIL full c%0d: obs=%b exp=%b", j + 1, obs_a, t[j]);
      end
    end
  endtask

  task automatic test_sparse_step3();
    logic [6:0] t [8] = '{
      7'b1011010, 7'b1011010, 7'b1011010,
      7'b1111010, 7'b1111010, 7'b1111010,
      7'b0000110, 7'b0000001
    };
    din = 4'b1111;
    msk = 4'b1010;
    vb = 1'b1;
    @(posedge clk);
    #1 vb = 1'b0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      total++;
      if (obs_b !== t[j]) begin
        bad++;
        $display("FAIL sparse c%0d: obs=%b exp=%b", j + 1, obs_b, t[j]);
      end
    end
  endtask

  task automatic test_zero_mask();
    logic [6:0] t [2] = '{7'b0000110, 7'b0000001};
    din = 4'b1111;
    msk = 4'b0000;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if (obs_a !== t[j]) begin
        bad++;
        $display("FAIL zero c%0d: obs=%b exp=%b", j + 1, obs_a, t[j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] t [2] = '{7'b1001010, 7'b1010010};
    logic [6:0] u [3] = '{7'b1001010, 7'b0000110, 7'b0000001};
    din = 4'b0101;
    msk = 4'hF;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      total++;
      if (obs_a !== t[j]) begin
        bad++;
        $display("FAIL mid c%0d: obs=%b exp=%b", j + 1, obs_a, t[j]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (obs_a !== 7'b0000000) begin
      bad++;
      $display("FAIL mid_rst: obs=%b exp=%b", obs_a, 7'b0000000);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (obs_a !== 7'b0000001) begin
      bad++;
      $display("FAIL mid_idle: obs=%b exp=%b", obs_a, 7'b0000001);
    end
    din = 4'b0001;
    msk = 4'b0001;
    va = 1'b1;
    @(posedge clk);
    #1 va = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      total++;
      if (obs_a !== u[j]) begin
        bad++;
        $display("FAIL mid_re c%0d: obs=%b exp=%b", j + 1, obs_a, u[j]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] t [9] = '{
      7'b1001010, 7'b1010010, 7'b0000110,
      7'b0000001, 7'b1000010, 7'b1011010,
      7'b0000110, 7'b0000001, 7'b0000001
    };
    din = 4'b0101;
    msk = 4'b0011;
    va = 1'b1;
    total++;
    if (obs_a !== 7'b0000001) begin
      bad++;
      $display("FAIL b2b_pre: obs=%b exp=%b", obs_a, 7'b0000001);
    end
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      total++;
      if (obs_a !== t[j]) begin
        bad++;
        $display("FAIL b2b c%0d: obs=%b exp=%b", j + 1, obs_a, t[j]);
      end
      if (j == 0) din = 4'b1010;
      if (j == 4) din = 4'b0101;
      if (j == 6) va = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_step3();
    test_zero_mask();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_1to4_sequencer.md
# demux_1to4_sequencer

Upstream driver for the 1-to-4 demultiplexer. Accepts a 4-bit word and a 4-bit channel mask over a valid/ready handshake, then walks the enabled channels in ascending order and presents one data bit per channel on `i`, `s1`, `s0` and `e` so the demux routes bit k to output yk. Completion is signalled with a one-cycle `done` pulse. Outputs connect directly to the demux `i/s0/s1/e` inputs.

## Interface
- `STEP_CYCLES`, default 1: cycles each enabled channel is held. Legal range is 1..255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream has a word to send.
- `in_ready` output 1: block can accept a word. High only in IDLE with `rst` low.
- `in_data` input 4: bit k is the value to route to demux output yk.
- `in_mask` input 4: bit k=1 means channel k is visited; 0 means it is skipped.
- `i` output 1: data bit to the demux.
- `s0` output 1: select LSB.
- `s1` output 1: select MSB.
- `e` output 1: demux enable. High only while a channel is being driven.
- `busy` output 1: high in DRIVE and DONE.
- `done` output 1: one-cycle pulse at the end of each transfer.

## Operation
- Handshake: a transfer is accepted on a rising edge where `in_valid & in_ready` is true. `in_data` and `in_mask` are captured at that edge. Later input changes are ignored until the next accept.
- FSM states:
  - IDLE: `in_ready`=1. On accept, go to DRIVE if the mask is nonzero, otherwise go to DONE.
  - DRIVE: `e`=1, `{s1,s0}`=ch, `i`=data[ch]. A step counter runs from 0 to STEP_CYCLES-1. At terminal count, ch becomes the next set mask bit above ch and the counter clears. If no set bit remains, go to DONE.
  - DONE: `done`=1, `e`=0, then go to IDLE.
- The first channel is the lowest set mask bit.
- Channels whose mask bit is 0 never appear on `{s1,s0}` with `e`=1.
- In IDLE and DONE: `i`=0, `s1`=0, `s0`=0, `e`=0.
- Outputs are decoded from registers only. No input-to-output combinational path except `in_ready`, which depends on `rst`.
- Reset values: state IDLE, ch=0, counter=0, `e`=0, `s1`=0, `s0`=0, `i`=0, `busy`=0, `done`=0. `in_ready`=0 while `rst` is high and 1 in the cycle after `rst` falls.
- Reset mid-transfer: the next edge forces IDLE. No `done` pulse is issued and the transfer is dropped.
- `in_valid` high while not ready: the block does not accept. Upstream must hold the word.

## Timing
- Accept at edge k. From cycle k+1, DRIVE presents the first channel for STEP_CYCLES cycles. Each subsequent enabled channel directly follows, with no gap cycles.
- After the last channel, there is one DONE cycle with `done`=1.
- `in_ready` returns high in the cycle after DONE.
- Total cycles from accept edge to `in_ready` high = popcount(mask)·STEP_CYCLES + 2.
- Zero mask: DONE at k+1, IDLE at k+2, and `e` never rises.
- Back-to-back transfers: a new accept is possible on the first IDLE cycle, so the minimum bubble is the DONE cycle plus one IDLE cycle.
- The step counter is 8 bits wide. Terminal count is STEP_CYCLES-1 with no wrap-around hazard. Channel index is 2 bits and never wraps past 3; the end of the mask goes to DONE.

## Structure
- Shared package `demux_seq_pkg` holds:
  - state encoding localparams: IDLE=2'd0, DRIVE=2'd1, DONE=2'd2;
  - NUM_CH=4;
  - SEL_W=2.
- Sub-module `demux_seq_next_ch` is combinational. Its inputs are mask[3:0] and current ch[1:0] plus a `first` flag. It outputs the next set bit index and a `found` flag. The same block serves both first-channel and next-channel lookup.
- The top level holds the FSM, the capture registers, the step counter and the output decode.
- Integration bench instantiates this block feeding `demux_1to4_gatelevel` and `demux_1to4_behavioural` and compares their outputs.

## Test plan
- Reset then idle, STEP_CYCLES=1: `e`=0, `s1`=0, `s0`=0, `i`=0, `done`=0, `in_ready`=1 one cycle after `rst` falls.
- in_data=4'b1010, in_mask=4'hF, STEP=1: cycles k+1..k+4 show `{s1,s0}`=0,1,2,3 with `i`=0,1,0,1 and `e`=1. Then `done` at k+5 and `in_ready` at k+6.
- in_data=4'b1111, in_mask=4'b1010, STEP=3: ch1 is held for cycles k+1..k+3, then ch3 for k+4..k+6. Select values 0 and 2 never appear with `e`=1. `done` at k+7.
- in_mask=0: no `e` assertion, `done` at k+1, `in_ready` at k+2.
- `rst` pulsed during the second channel of a full-mask transfer: the next cycle is IDLE with all outputs 0, no `done` pulse, and a following transfer completes normally.
- `in_valid` held high continuously with alternating words: each word is accepted exactly once, only in IDLE, and `in_data` changes during DRIVE do not alter `i`.
